// File: rtl/gate_guard_pkg.sv
// gate_guard_pkg: shared definitions for the gate_guard protection stage.
//   - state_t   : FSM state encoding (OFF / G1_ON / G2_ON / FAULT)
//   - FC_*      : fault codes reported on o_fault_code
package gate_guard_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_G1_ON = 2'd1,
        ST_G2_ON = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_SHOOT = 2'b01;
    localparam logic [1:0] FC_MAXON = 2'b10;
    localparam logic [1:0] FC_OCP   = 2'b11;

endpackage

// File: rtl/gate_guard_sync.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous, active-low reset (both flops cleared)
//   d    - asynchronous input
//   q    - synchronized output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/gate_guard.sv
// gate_guard: protection stage between the DPWM and the power-stage gate drivers.
// Enforces a minimum dead time between the two gates, and latches a fault with
// both gates off on shoot-through, max on-time overrun or over-current (OCP).
// A latched fault is left only through an explicit clear request.
// Optional feature: define GATE_GUARD_BLANK_EN to add leading-edge blanking of
// the OCP input for BLANK cycles after each gate turn-on.
// Ports:
//   clk          - 200 MHz clock
//   rst          - synchronous, active-low reset
//   i_c1, i_c2   - raw high-side / low-side gate commands
//   i_ocp        - asynchronous over-current comparator, active-high
//   i_clr_fault  - fault clear request (level)
//   o_g1, o_g2   - guarded gates, registered
//   o_fault      - fault latched
//   o_fault_code - 00 none, 01 shoot-through, 10 max on-time, 11 OCP
//   o_dt_stretch - one-cycle pulse when a turn-on was delayed by the dead time
module gate_guard
    import gate_guard_pkg::*;
#(
    parameter int DT_MIN = 4,
    parameter int MAX_ON = 2000,
    parameter int CW     = 11,
    parameter int BLANK  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_c1,
    input  logic       i_c2,
    input  logic       i_ocp,
    input  logic       i_clr_fault,
    output logic       o_g1,
    output logic       o_g2,
    output logic       o_fault,
    output logic [1:0] o_fault_code,
    output logic       o_dt_stretch
);

    // Loading DT_MIN-1 yields exactly DT_MIN cycles with both gates low,
    // because the cycle that leaves the ON state already counts as one.
    localparam logic [3:0]    DT_LOAD = 4'(DT_MIN - 1);
    localparam logic [CW-1:0] ON_LAST = CW'(MAX_ON - 1);

    logic          ocp_s;
    logic          ocp_hit;
    state_t        state_reg,   state_next;
    logic [3:0]    dt_cnt_reg,  dt_cnt_next;
    logic [CW-1:0] on_cnt_reg,  on_cnt_next;
    logic [1:0]    code_reg,    code_next;
    logic          pend_reg,    pend_next;     // a request was held off by dt_cnt last cycle
    logic          stretch_reg, stretch_next;
    logic          g1_reg, g2_reg, fault_reg;

    sync_2ff u_sync_ocp (
        .clk (clk),
        .rst (rst),
        .d   (i_ocp),
        .q   (ocp_s)
    );

`ifdef GATE_GUARD_BLANK_EN
    localparam int BW = $clog2(BLANK + 1);
    logic [BW-1:0] blank_cnt_reg, blank_cnt_next;

    // OCP is masked only while a gate is on and the blanking window is open.
    assign ocp_hit = ocp_s && !(((state_reg == ST_G1_ON) || (state_reg == ST_G2_ON))
                                && (blank_cnt_reg != '0));
`else
    assign ocp_hit = ocp_s;
`endif

    always_comb begin
        state_next   = state_reg;
        dt_cnt_next  = dt_cnt_reg;
        on_cnt_next  = on_cnt_reg;
        code_next    = code_reg;
        pend_next    = 1'b0;
        stretch_next = 1'b0;
`ifdef GATE_GUARD_BLANK_EN
        blank_cnt_next = (blank_cnt_reg != '0) ? blank_cnt_reg - BW'(1) : blank_cnt_reg;
`endif
        case (state_reg)
            ST_OFF: begin
                if (ocp_hit) begin
                    state_next = ST_FAULT;
                    code_next  = FC_OCP;
                end else if (dt_cnt_reg != 4'd0) begin
                    dt_cnt_next = dt_cnt_reg - 4'd1;
                    pend_next   = i_c1 | i_c2;
                end else if (i_c1 && i_c2) begin
                    state_next = ST_FAULT;
                    code_next  = FC_SHOOT;
                end else if (i_c1 || i_c2) begin
                    state_next   = i_c1 ? ST_G1_ON : ST_G2_ON;
                    on_cnt_next  = '0;
                    stretch_next = pend_reg;
`ifdef GATE_GUARD_BLANK_EN
                    blank_cnt_next = BW'(BLANK);
`endif
                end
            end
            ST_G1_ON, ST_G2_ON: begin
                // own/other select the raw command for this gate and the opposite one
                if (ocp_hit) begin
                    state_next = ST_FAULT;
                    code_next  = FC_OCP;
                end else if ((state_reg == ST_G1_ON) ? i_c2 : i_c1) begin
                    state_next = ST_FAULT;
                    code_next  = FC_SHOOT;
                end else if (!((state_reg == ST_G1_ON) ? i_c1 : i_c2)) begin
                    state_next  = ST_OFF;
                    dt_cnt_next = DT_LOAD;
                end else if (on_cnt_reg == ON_LAST) begin
                    state_next = ST_FAULT;
                    code_next  = FC_MAXON;
                end else begin
                    on_cnt_next = on_cnt_reg + CW'(1);
                end
            end
            ST_FAULT: begin
                if (i_clr_fault && !i_c1 && !i_c2 && !ocp_s) begin
                    state_next  = ST_OFF;
                    dt_cnt_next = DT_LOAD;
                    code_next   = FC_NONE;
                end
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_OFF;
            dt_cnt_reg  <= 4'd0;
            on_cnt_reg  <= '0;
            code_reg    <= FC_NONE;
            pend_reg    <= 1'b0;
            stretch_reg <= 1'b0;
            g1_reg      <= 1'b0;
            g2_reg      <= 1'b0;
            fault_reg   <= 1'b0;
`ifdef GATE_GUARD_BLANK_EN
            blank_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            dt_cnt_reg  <= dt_cnt_next;
            on_cnt_reg  <= on_cnt_next;
            code_reg    <= code_next;
            pend_reg    <= pend_next;
            stretch_reg <= stretch_next;
            g1_reg      <= (state_next == ST_G1_ON);
            g2_reg      <= (state_next == ST_G2_ON);
            fault_reg   <= (state_next == ST_FAULT);
`ifdef GATE_GUARD_BLANK_EN
            blank_cnt_reg <= blank_cnt_next;
`endif
        end
    end

    assign o_g1         = g1_reg;
    assign o_g2         = g2_reg;
    assign o_fault      = fault_reg;
    assign o_fault_code = code_reg;
    assign o_dt_stretch = stretch_reg;

endmodule
